// File: rtl/shift_add_multiplier_pkg.sv
// ============================================================================
// Module   : shift_add_multiplier_pkg
// Brief    : Shared state encoding for the sequential shift-and-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

`default_nettype wire

// File: rtl/shift_add_multiplier_shifter.sv
// ============================================================================
// Module   : Shifter
// Brief    : Combinational barrel shifter with logical shift and rotate modes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module Shifter #(
  parameter int BitWidth = 16
) (
  input  logic [BitWidth-1:0]         dIN,
  input  logic [$clog2(BitWidth)-1:0] ShAmount,
  input  logic                        En,
  input  logic                        Left,
  input  logic                        RotateEnable,
  output logic [BitWidth-1:0]         dOUT
);

  localparam int AW = $clog2(BitWidth);

  logic [AW:0]          inv_amt;
  logic [BitWidth-1:0]  rot_left;
  logic [BitWidth-1:0]  rot_right;

  // A shift by the full width yields zero, so a zero amount rotates cleanly.
  assign inv_amt   = (AW+1)'(BitWidth) - {1'b0, ShAmount};
  assign rot_left  = (dIN << ShAmount) | (dIN >> inv_amt);
  assign rot_right = (dIN >> ShAmount) | (dIN << inv_amt);

  always_comb begin
    dOUT = dIN;
    if (En) begin
      case ({Left, RotateEnable})
        2'b10:   dOUT = dIN << ShAmount;
        2'b11:   dOUT = rot_left;
        2'b01:   dOUT = rot_right;
        default: dOUT = dIN >> ShAmount;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_add_multiplier.sv
// ============================================================================
// Module   : shift_add_multiplier
// Brief    : Unsigned sequential multiplier, one multiplier bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int BitWidth = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [BitWidth-1:0]   A,
  input  logic [BitWidth-1:0]   B,
  output logic                  Ready,
  output logic                  Busy,
  output logic                  Done,
  output logic [2*BitWidth-1:0] Product
);

  localparam int PW = 2 * BitWidth;
  localparam int CW = $clog2(PW);
  localparam logic [CW-1:0] LAST_COUNT = CW'(BitWidth - 1);

  mul_state_t    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [BitWidth-1:0] mplier_q, mplier_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] product_q, product_d;

  logic [PW-1:0] shifted;
  logic [PW-1:0] mplier_ext;
  logic          bit_set;
  logic [PW-1:0] sum;

  Shifter #(
    .BitWidth (PW)
  ) u_shifter (
    .dIN          (mcand_q),
    .ShAmount     (count_q),
    .En           (1'b1),
    .Left         (1'b1),
    .RotateEnable (1'b0),
    .dOUT         (shifted)
  );

  // Widening the multiplier lets the counter index it without truncation.
  assign mplier_ext = {{BitWidth{1'b0}}, mplier_q};
  assign bit_set    = mplier_ext[count_q];
  assign sum        = bit_set ? (acc_q + shifted) : acc_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    product_d = product_q;
    case (state_q)
      RUN: begin
        acc_d = sum;
        if (count_q == LAST_COUNT) begin
          product_d = sum;
          state_d   = DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        if (Start) begin
          state_d  = RUN;
          mcand_d  = {{BitWidth{1'b0}}, A};
          mplier_d = B;
          acc_d    = '0;
          count_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign Ready   = (state_q != RUN);
  assign Busy    = (state_q == RUN);
  assign Done    = (state_q == DONE);
  assign Product = product_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
// ============================================================================
// Module   : tb_shift_add_multiplier
// Brief    : Self-checking bench for the shift-and-add multiplier, BitWidth=8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_add_multiplier;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        Ready;
  logic        Busy;
  logic        Done;
  logic [15:0] Product;

  int errs   = 0;
  int checks = 0;

  shift_add_multiplier #(
    .BitWidth (8)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Start   (Start),
    .A       (A),
    .B       (B),
    .Ready   (Ready),
    .Busy    (Busy),
    .Done    (Done),
    .Product (Product)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference product is plain integer multiplication.
  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    return 16'(a) * 16'(b);
  endfunction

  // One isolated multiply: latency, result, Ready on Done, single-cycle pulse.
  task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input string nm);
    int lat;
    @(negedge Clk);
    chk({nm, " ready_before"}, 32'(Ready), 32'd1);
    Start = 1'b1; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0; A = 8'($urandom); B = 8'($urandom);
    chk({nm, " busy"}, 32'(Busy), 32'd1);
    lat = 1;
    while (!Done && lat < 30) begin
      @(negedge Clk);
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'd9);
    chk({nm, " product"}, 32'(Product), 32'(ref_mul(a, b)));
    chk({nm, " ready_on_done"}, 32'(Ready), 32'd1);
    @(negedge Clk);
    chk({nm, " done_pulse"}, 32'(Done), 32'd0);
  endtask

  initial begin
    vec_t vecs[6];
    int   lat;
    int   ndone;
    logic ready_gap_ok;
    logic [7:0] ra, rb;

    vecs[0] = '{8'd13,  8'd11,  16'd143};
    vecs[1] = '{8'd255, 8'd255, 16'd65025};
    vecs[2] = '{8'd0,   8'd200, 16'd0};
    vecs[3] = '{8'd200, 8'd0,   16'd0};
    vecs[4] = '{8'd1,   8'd255, 16'd255};
    vecs[5] = '{8'd128, 8'd2,   16'd256};

    Rst = 1'b1; Start = 1'b0; A = '0; B = '0;
    #1;
    chk("reset ready",   32'(Ready),   32'd1);
    chk("reset busy",    32'(Busy),    32'd0);
    chk("reset done",    32'(Done),    32'd0);
    chk("reset product", 32'(Product), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;

    // Table: each entry's expected product is fixed by hand.
    foreach (vecs[i]) begin
      do_mul(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table", i), 32'(Product), 32'(vecs[i].exp));
    end

    // Randomized operands against the reference model.
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_mul(ra, rb, $sformatf("rand%0d", i));
    end

    // Start pulsed during RUN must be ignored.
    @(negedge Clk);
    Start = 1'b1; A = 8'd10; B = 8'd10;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Start = 1'b1; A = 8'd3; B = 8'd3;
    @(negedge Clk);
    Start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      if (Done) begin
        ndone++;
        chk("ignored product", 32'(Product), 32'd100);
      end
      @(negedge Clk);
    end
    chk("ignored done_count", 32'(ndone), 32'd1);
    chk("ignored idle_ready", 32'(Ready), 32'd1);
    chk("ignored idle_busy",  32'(Busy),  32'd0);

    // Back-to-back with Start held high.
    @(negedge Clk);
    Start = 1'b1; A = 8'd5; B = 8'd6;
    @(negedge Clk);
    A = 8'd7; B = 8'd8;
    lat = 1;
    while (!Done && lat < 30) begin
      @(negedge Clk);
      lat++;
    end
    chk("b2b first_latency", 32'(lat), 32'd9);
    chk("b2b first_product", 32'(Product), 32'd30);
    @(negedge Clk);
    Start = 1'b0;
    lat = 1;
    ready_gap_ok = 1'b1;
    while (!Done && lat < 30) begin
      if (Ready) ready_gap_ok = 1'b0;
      @(negedge Clk);
      lat++;
    end
    chk("b2b ready_low_between", 32'(ready_gap_ok), 32'd1);
    chk("b2b second_latency", 32'(lat), 32'd9);
    chk("b2b second_product", 32'(Product), 32'd56);

    // Asynchronous reset in the middle of an operation.
    @(negedge Clk);
    Start = 1'b1; A = 8'd99; B = 8'd77;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    chk("abort product", 32'(Product), 32'd0);
    chk("abort busy",    32'(Busy),    32'd0);
    chk("abort ready",   32'(Ready),   32'd1);
    chk("abort done",    32'(Done),    32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge Clk);
      if (Done) ndone++;
    end
    chk("abort no_done", 32'(ndone), 32'd0);
    do_mul(8'd4, 8'd4, "after_abort");

    // Product holds while inputs wander with Start low.
    do_mul(8'd9, 8'd9, "hold");
    for (int c = 0; c < 20; c++) begin
      A = 8'($urandom);
      B = 8'($urandom);
      @(negedge Clk);
      chk("hold product", 32'(Product), 32'd81);
      chk("hold done",    32'(Done),    32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

`default_nettype wire
